// File: rtl/cpu_sequencer.sv
// Five-state instruction sequencer for the 8-bit CPU: fetches a 3-byte instruction,
// executes it in the store state, and owns the RAM address/data/write-enable lines.
module cpu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    input  logic [7:0] mem_rdata,
    output logic [7:0] acc,
    output logic       carry,
    output logic [7:0] out_reg,
    output logic [7:0] pc,
    output logic [2:0] state,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_FETCH1  = 3'd1,
        S_FETCH2  = 3'd2,
        S_FETCH3  = 3'd3,
        S_COMPUTE = 3'd4,
        S_STORE   = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [7:0] OP_HALT  = 8'h00;
    localparam logic [7:0] OP_LOADI = 8'h01;
    localparam logic [7:0] OP_LOAD  = 8'h02;
    localparam logic [7:0] OP_STORE = 8'h03;
    localparam logic [7:0] OP_ADD   = 8'h04;
    localparam logic [7:0] OP_JMP   = 8'h05;
    localparam logic [7:0] OP_JZ    = 8'h06;
    localparam logic [7:0] OP_OUT   = 8'h07;
    localparam logic [7:0] OP_STI   = 8'h08;

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_pc;
    logic [7:0] r_acc;
    logic       r_carry;
    logic [7:0] r_out;
    logic [7:0] r_opcode;
    logic [7:0] r_op1;
    logic [7:0] r_op2;
    logic [8:0] w_sum;
    logic       w_is_write;

    assign w_sum      = {1'b0, r_acc} + {1'b0, mem_rdata};
    assign w_is_write = (r_opcode == OP_STORE) || (r_opcode == OP_STI);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH1;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH1:  w_next = run ? S_FETCH2 : S_FETCH1;
            S_FETCH2:  w_next = S_FETCH3;
            S_FETCH3:  w_next = S_COMPUTE;
            S_COMPUTE: w_next = S_STORE;
            S_STORE:   w_next = (r_opcode == OP_HALT) ? S_HALT : S_FETCH1;
            S_HALT:    w_next = S_HALT;
            default:   w_next = S_FETCH1;
        endcase
    end

    // RAM data lags the address by one cycle, so each fetch state captures the
    // byte addressed by the state before it; store sees mem[op1] from compute.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_acc    <= 8'h00;
            r_carry  <= 1'b0;
            r_out    <= 8'h00;
            r_opcode <= 8'h00;
            r_op1    <= 8'h00;
            r_op2    <= 8'h00;
        end else begin
            case (r_state)
                S_FETCH2:  r_opcode <= mem_rdata;
                S_FETCH3:  r_op1    <= mem_rdata;
                S_COMPUTE: begin
                    r_op2 <= mem_rdata;
                    r_pc  <= r_pc + 8'd3;
                end
                S_STORE: begin
                    case (r_opcode)
                        OP_LOADI: r_acc <= r_op1;
                        OP_LOAD:  r_acc <= mem_rdata;
                        OP_ADD:   {r_carry, r_acc} <= w_sum;
                        OP_JMP:   r_pc <= r_op1;
                        OP_JZ: begin
                            if (r_acc == 8'h00) r_pc <= r_op1;
                        end
                        OP_OUT:   r_out <= r_acc;
                        default:  ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_addr = r_pc;
        case (r_state)
            S_FETCH1:  mem_addr = r_pc;
            S_FETCH2:  mem_addr = r_pc + 8'd1;
            S_FETCH3:  mem_addr = r_pc + 8'd2;
            S_COMPUTE: mem_addr = r_op1;
            S_STORE:   mem_addr = r_op1;
            default:   mem_addr = r_pc;
        endcase
    end

    // Reset gates the write enable directly so a store interrupted by reset never lands.
    assign mem_we    = !reset && (r_state == S_STORE) && w_is_write;
    assign mem_wdata = ((r_state == S_STORE) && (r_opcode == OP_STI)) ? r_op2 : r_acc;

    assign acc     = r_acc;
    assign carry   = r_carry;
    assign out_reg = r_out;
    assign pc      = r_pc;
    assign state   = r_state;
    assign halted  = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a behavioural RAM, directed programs, and a
// write scoreboard whose monitor checks every cycle the DUT asserts mem_we.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b1;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic [7:0] acc;
    logic       carry;
    logic [7:0] out_reg;
    logic [7:0] pc;
    logic [2:0] state;
    logic       halted;

    logic [7:0] ram [256];
    logic       tb_clr = 1'b0;
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'h00;
    logic [7:0] tb_data = 8'h00;

    logic [15:0] exp_q [$];
    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.RESET_PC(8'h10)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .acc(acc), .carry(carry), .out_reg(out_reg),
        .pc(pc), .state(state), .halted(halted)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read; bench preload has priority over DUT writes.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (tb_we) begin
            ram[tb_addr] <= tb_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Write monitor: every asserted mem_we must match the next expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write", mem_addr, mem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                             mem_addr, mem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    task automatic poke3(input logic [7:0] a, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        poke(a, b0);
        poke(a + 8'd1, b1);
        poke(a + 8'd2, b2);
    endtask

    task automatic begin_test();
        reset = 1'b1;
        run = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        tb_clr = 1'b1;
        @(posedge clk);
        #1;
        tb_clr = 1'b0;
    endtask

    // Check the reset state, then release reset just after a rising edge.
    task automatic release_reset(input string tag);
        @(negedge clk);
        chk({tag, "_rst_pc"}, {8'h0, pc}, 16'h10);
        chk({tag, "_rst_state"}, {13'h0, state}, 16'd1);
        chk({tag, "_rst_addr"}, {8'h0, mem_addr}, 16'h10);
        chk({tag, "_rst_we"}, {15'h0, mem_we}, 16'd0);
        chk({tag, "_rst_acc"}, {8'h0, acc}, 16'h00);
        chk({tag, "_rst_out"}, {8'h0, out_reg}, 16'h00);
        chk({tag, "_rst_carry_halt"}, {14'h0, carry, halted}, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            step(1);
            n++;
        end
        chk({tag, "_halt_reached"}, {15'h0, halted}, 16'd1);
    endtask

    initial begin
        // Arithmetic: LOADI 05, ADD 20, OUT, HALT with mem[20]=FE
        begin_test();
        poke3(8'h10, 8'h01, 8'h05, 8'h00);
        poke3(8'h13, 8'h04, 8'h20, 8'h00);
        poke3(8'h16, 8'h07, 8'h00, 8'h00);
        poke(8'h20, 8'hFE);
        release_reset("arith");
        step(19);
        chk("arith_halted_early", {15'h0, halted}, 16'd0);
        step(1);
        chk("arith_halted_20", {15'h0, halted}, 16'd1);
        chk("arith_state", {13'h0, state}, 16'd6);
        chk("arith_acc", {8'h0, acc}, 16'h03);
        chk("arith_carry", {15'h0, carry}, 16'd1);
        chk("arith_out", {8'h0, out_reg}, 16'h03);
        chk("arith_addr", {8'h0, mem_addr}, 16'h1C);
        run = 1'b0;
        step(3);
        run = 1'b1;
        step(2);
        chk("arith_halt_hold", {7'h0, halted, mem_addr}, 16'h11C);

        // Writes: LOADI A5, STORE 40, STI 41 3C, HALT
        begin_test();
        poke3(8'h10, 8'h01, 8'hA5, 8'h00);
        poke3(8'h13, 8'h03, 8'h40, 8'h00);
        poke3(8'h16, 8'h08, 8'h41, 8'h3C);
        exp_q.push_back(16'h40A5);
        exp_q.push_back(16'h413C);
        release_reset("wr");
        wait_halt("wr", 40);
        chk("wr_pending", 16'(exp_q.size()), 16'd0);
        chk("wr_mem40", {8'h0, ram[8'h40]}, 16'hA5);
        chk("wr_mem41", {8'h0, ram[8'h41]}, 16'h3C);
        chk("wr_pc", {8'h0, pc}, 16'h1C);

        // JZ taken: LOADI 00, JZ 30; HALT at 30
        begin_test();
        poke3(8'h10, 8'h01, 8'h00, 8'h00);
        poke3(8'h13, 8'h06, 8'h30, 8'h00);
        release_reset("jzt");
        step(10);
        chk("jzt_pc", {8'h0, pc}, 16'h30);
        chk("jzt_fetch", {5'h0, state, mem_addr}, 16'h130);
        wait_halt("jzt", 20);
        chk("jzt_halt_pc", {8'h0, pc}, 16'h33);

        // JZ not taken: LOADI 01, JZ 30, HALT
        begin_test();
        poke3(8'h10, 8'h01, 8'h01, 8'h00);
        poke3(8'h13, 8'h06, 8'h30, 8'h00);
        release_reset("jzn");
        step(10);
        chk("jzn_pc", {8'h0, pc}, 16'h16);
        wait_halt("jzn", 20);
        chk("jzn_halt_pc", {8'h0, pc}, 16'h19);
        chk("jzn_acc_carry", {7'h0, carry, acc}, 16'h001);

        // JMP FE, LOADI 77 spanning FE/FF/00, HALT at 01
        begin_test();
        poke3(8'h10, 8'h05, 8'hFE, 8'h00);
        poke(8'hFE, 8'h01);
        poke(8'hFF, 8'h77);
        release_reset("wrap");
        step(5);
        chk("wrap_f1", {5'h0, state, mem_addr}, 16'h1FE);
        step(1);
        chk("wrap_f2", {5'h0, state, mem_addr}, 16'h2FF);
        step(1);
        chk("wrap_f3", {5'h0, state, mem_addr}, 16'h300);
        step(3);
        chk("wrap_next", {5'h0, state, pc}, 16'h101);
        chk("wrap_acc", {8'h0, acc}, 16'h77);
        wait_halt("wrap", 20);
        chk("wrap_halt_pc", {8'h0, pc}, 16'h04);

        // Stall: run dropped in compute of LOADI 11; then STORE 50, HALT
        begin_test();
        poke3(8'h10, 8'h01, 8'h11, 8'h00);
        poke3(8'h13, 8'h03, 8'h50, 8'h00);
        exp_q.push_back(16'h5011);
        release_reset("stall");
        step(3);
        chk("stall_compute", {13'h0, state}, 16'd4);
        run = 1'b0;
        step(2);
        chk("stall_done", {5'h0, state, acc}, 16'h111);
        step(4);
        chk("stall_hold", {5'h0, state, mem_addr}, 16'h113);
        chk("stall_pc", {8'h0, pc}, 16'h13);
        run = 1'b1;
        step(1);
        chk("stall_resume", {13'h0, state}, 16'd2);
        wait_halt("stall", 20);
        chk("stall_pending", 16'(exp_q.size()), 16'd0);
        chk("stall_mem50", {8'h0, ram[8'h50]}, 16'h11);

        // Reset asserted during store of STORE 60: no write reaches memory
        begin_test();
        poke3(8'h10, 8'h01, 8'h22, 8'h00);
        poke3(8'h13, 8'h03, 8'h60, 8'h00);
        poke(8'h60, 8'h99);
        release_reset("mrst");
        step(8);
        chk("mrst_compute", {13'h0, state}, 16'd4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_store_we", {13'h0, state[1:0], mem_we}, 16'b010);
        step(1);
        chk("mrst_after", {5'h0, state, pc}, 16'h110);
        chk("mrst_acc", {8'h0, acc}, 16'h00);
        chk("mrst_mem60", {8'h0, ram[8'h60]}, 16'h99);

        // Unused opcode 2A, then LOAD 71, OUT, HALT
        begin_test();
        poke3(8'h10, 8'h01, 8'h5A, 8'h00);
        poke3(8'h13, 8'h2A, 8'h70, 8'h71);
        poke3(8'h16, 8'h02, 8'h71, 8'h00);
        poke3(8'h19, 8'h07, 8'h00, 8'h00);
        poke(8'h70, 8'hC3);
        poke(8'h71, 8'h3C);
        release_reset("nop");
        step(10);
        chk("nop_pc", {8'h0, pc}, 16'h16);
        chk("nop_acc", {8'h0, acc}, 16'h5A);
        chk("nop_carry_out", {7'h0, carry, out_reg}, 16'h000);
        wait_halt("nop", 30);
        chk("nop_load_out", {acc, out_reg}, 16'h3C3C);
        chk("nop_mem", {ram[8'h70], ram[8'h71]}, 16'hC33C);
        chk("nop_halt_pc", {8'h0, pc}, 16'h1F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Instruction sequencer for the 8-bit CPU. It owns the single-port 256x8 RAM's address, write-data and write-enable lines, and steps through a fixed five-state cycle per instruction: fetch opcode, fetch operand1, fetch operand2, compute, store. It holds the accumulator, program counter, carry and output register, and exports them so the top level can route them to the LED scanner.

## Interface
- RESET_PC, 8'h00, value loaded into pc on reset.

- clk  in  1  system clock (12 MHz board clock).
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = execute; 0 = stall at the instruction boundary (in fetch1).
- mem_addr  out  8  RAM address.
- mem_wdata  out  8  RAM write data.
- mem_we  out  1  RAM write enable; RAM writes mem_wdata at mem_addr on the clk edge.
- mem_rdata  in  8  RAM read data. Valid the cycle after mem_addr is driven.
- acc  out  8  accumulator.
- carry  out  1  carry from the last ADD.
- out_reg  out  8  output latch written by OUT (drives the LEDs).
- pc  out  8  program counter.
- state  out  3  current state, for debug.
- halted  out  1  1 once HALT has executed.

## Operation
- **Instruction format:** 3 bytes at pc, pc+1, pc+2: opcode, op1, op2. All pc arithmetic is mod 256.
- **State encoding:** fetch1=1, fetch2=2, fetch3=3, compute=4, store=5, halt=6.
- **Memory outputs:** mem_addr, mem_we and mem_wdata are combinational decodes of state and registers only. There is no path from any input to them, except that reset forces mem_we=0.
- **fetch1:** addr=pc.
  - If run=0, stay in fetch1.
  - Otherwise go to fetch2.
- **fetch2:** opcode<=mem_rdata; addr=pc+1.
- **fetch3:** op1<=mem_rdata; addr=pc+2.
- **compute:** op2<=mem_rdata; pc<=pc+3; addr=op1.
- **store:** performs the opcode action, then goes to fetch1, or to halt for HALT.
- **Opcode actions** (opcode taken as the full 8 bits):
  - 00 HALT: enter halt.
  - 01 LOADI: acc<=op1.
  - 02 LOAD: acc<=mem_rdata (the value of mem[op1]).
  - 03 STORE: mem_we=1, addr=op1, wdata=acc.
  - 04 ADD: {carry,acc}<=acc+mem_rdata, as a 9-bit sum.
  - 05 JMP: pc<=op1.
  - 06 JZ: pc<=op1 if acc==0; otherwise pc keeps pc+3.
  - 07 OUT: out_reg<=acc.
  - 08 STI: mem_we=1, addr=op1, wdata=op2.
  - All other opcodes: NOP.
- **Carry:** only ADD modifies carry.
- **halt state:** addr=pc, mem_we=0, halted=1. The state is left only by reset. run is ignored.
- **mem_we:** is 1 only in store for STORE or STI, and never while reset=1.
- **mem_wdata:** equals acc in every state other than store with STI.

## Timing
- **Reset:** the cycle after reset is sampled high:
  - state=fetch1, pc=RESET_PC, acc=0, carry=0, out_reg=0, halted=0.
  - opcode, op1 and op2 = 0.
  - mem_addr=RESET_PC, mem_we=0.
- **Reset priority:** reset overrides everything, including reset asserted mid-store; the pending write is suppressed in that cycle.
- **Instruction length:** exactly 5 cycles per instruction with run=1; there are no wait states.
- **Register update:** registers update on the store→fetch1 edge, so the next fetch1 uses the updated pc.
- **Wrap-around:** at pc=FE, fetches come from FE, FF, 00, and pc becomes 01.
- **JMP/JZ priority:** JMP and taken JZ override the pc+3 written in compute.
- **run deassertion:** run=0 outside fetch1 has no effect until the machine next reaches fetch1. run re-asserted lets fetch2 follow in the next cycle.
- **halted timing:** halted rises on the cycle after the HALT instruction's store state.

## Test plan
- **Reset:** hold reset 2 cycles with RESET_PC=10 → pc=10, state=1, mem_addr=10, mem_we=0, acc=0, out_reg=0, halted=0.
- **Arithmetic program:** mem[0x20]=FE; program LOADI 05, ADD 20, OUT, HALT from 00 → acc=03, carry=1, out_reg=03. halted rises exactly 20 cycles after reset release and mem_addr stays 0C.
- **Writes:** program LOADI A5, STORE 40, STI 41 3C → mem_we high for exactly one cycle each, at (40, A5) and (41, 3C). mem[40]=A5, mem[41]=3C.
- **Branches:**
  - acc=0, JZ 30 → pc=30.
  - acc=1, JZ 30 → pc=pc+3.
  - JMP FE with an instruction at FE → fetch addresses FE, FF, 00, then pc=01.
- **Stall and mid-write reset:**
  - run=0 during compute → the instruction completes, then the sequencer stays in fetch1 with mem_addr=pc.
  - run=1 → fetch2 in the next cycle.
  - reset asserted in store of STORE → mem_we=0 that cycle, memory unchanged.
- **Unused opcode:** opcode 2A → no register or memory change, pc+=3.
